// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one execute ALU between exec and branch requesters
`timescale 1ns/1ps

module alu_share_arbiter #(
  parameter int WIDTH    = 32,
  parameter int OPCODE_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          REQ_VALID,
  output logic [1:0]          REQ_READY,
  input  logic [WIDTH-1:0]    REQ_A0,
  input  logic [WIDTH-1:0]    REQ_A1,
  input  logic [WIDTH-1:0]    REQ_B0,
  input  logic [WIDTH-1:0]    REQ_B1,
  input  logic [6:0]          REQ_F70,
  input  logic [6:0]          REQ_F71,
  input  logic [2:0]          REQ_F30,
  input  logic [2:0]          REQ_F31,
  input  logic [OPCODE_W-1:0] REQ_OP0,
  input  logic [OPCODE_W-1:0] REQ_OP1,
  output logic [WIDTH-1:0]    ALU_A,
  output logic [WIDTH-1:0]    ALU_B,
  output logic [6:0]          ALU_F7,
  output logic [2:0]          ALU_F3,
  output logic [OPCODE_W-1:0] ALU_OP,
  input  logic [WIDTH-1:0]    ALU_Y,
  input  logic                ALU_C,
  input  logic                ALU_V,
  input  logic                ALU_N,
  input  logic                ALU_ZERO,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic                RSP_ID,
  output logic [WIDTH-1:0]    RSP_Y,
  output logic [3:0]          RSP_FLAGS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       last;
  logic [1:0] grant;

  // Tie goes to the port that did not win last; only offered while idle.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !RST) begin
      case (REQ_VALID)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign REQ_READY = grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last      <= 1'b1;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_F7    <= '0;
      ALU_F3    <= '0;
      ALU_OP    <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= 1'b0;
      RSP_Y     <= '0;
      RSP_FLAGS <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant[0]) begin
            ALU_A  <= REQ_A0;
            ALU_B  <= REQ_B0;
            ALU_F7 <= REQ_F70;
            ALU_F3 <= REQ_F30;
            ALU_OP <= REQ_OP0;
            RSP_ID <= 1'b0;
            state  <= EXEC;
          end else if (grant[1]) begin
            ALU_A  <= REQ_A1;
            ALU_B  <= REQ_B1;
            ALU_F7 <= REQ_F71;
            ALU_F3 <= REQ_F31;
            ALU_OP <= REQ_OP1;
            RSP_ID <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // ALU flags are forwarded exactly as the ALU produced them.
          RSP_Y     <= ALU_Y;
          RSP_FLAGS <= {ALU_C, ALU_V, ALU_N, ALU_ZERO};
          RSP_VALID <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            last      <= RSP_ID;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and random checks of alu_share_arbiter against a reference model
`timescale 1ns/1ps

module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int OW = 8;

  logic          CLK, RST;
  logic [1:0]    REQ_VALID, REQ_READY;
  logic [W-1:0]  REQ_A0, REQ_A1, REQ_B0, REQ_B1;
  logic [6:0]    REQ_F70, REQ_F71;
  logic [2:0]    REQ_F30, REQ_F31;
  logic [OW-1:0] REQ_OP0, REQ_OP1;
  logic [W-1:0]  ALU_A, ALU_B, ALU_Y;
  logic [6:0]    ALU_F7;
  logic [2:0]    ALU_F3;
  logic [OW-1:0] ALU_OP;
  logic          ALU_C, ALU_V, ALU_N, ALU_ZERO;
  logic          RSP_VALID, RSP_READY, RSP_ID;
  logic [W-1:0]  RSP_Y;
  logic [3:0]    RSP_FLAGS;

  logic [W-1:0]  fa [2];
  logic [W-1:0]  fb [2];
  logic [6:0]    f7 [2];
  logic [2:0]    f3 [2];
  logic [OW-1:0] fop [2];

  int   checks = 0;
  int   errors = 0;
  logic m_last;
  logic last_id;
  logic [W-1:0] last_y;
  logic [3:0]   last_flags;

  assign REQ_A0 = fa[0];  assign REQ_A1 = fa[1];
  assign REQ_B0 = fb[0];  assign REQ_B1 = fb[1];
  assign REQ_F70 = f7[0]; assign REQ_F71 = f7[1];
  assign REQ_F30 = f3[0]; assign REQ_F31 = f3[1];
  assign REQ_OP0 = fop[0]; assign REQ_OP1 = fop[1];

  // Reference ALU: returns {C, V, N, Zero, Y}.
  function automatic logic [W+3:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [6:0] fs, input logic [2:0] ft);
    logic [W:0]   s;
    logic [W-1:0] y;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    case (ft)
      3'd4: y = a ^ b;
      3'd6: y = a | b;
      3'd7: y = a & b;
      default: begin
        if (fs[5]) begin
          s = {1'b0, a} + {1'b0, ~b} + 1;
          y = s[W-1:0];
          c = s[W];
          v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
        end else begin
          s = {1'b0, a} + {1'b0, b};
          y = s[W-1:0];
          c = s[W];
          v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
        end
      end
    endcase
    return {c, v, y[W-1], (y == '0), y};
  endfunction

  logic [W+3:0] alu_out;
  always_comb alu_out = ref_alu(ALU_A, ALU_B, ALU_F7, ALU_F3);
  assign {ALU_C, ALU_V, ALU_N, ALU_ZERO, ALU_Y} = alu_out;

  alu_share_arbiter #(.WIDTH(W), .OPCODE_W(OW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A0(REQ_A0), .REQ_A1(REQ_A1), .REQ_B0(REQ_B0), .REQ_B1(REQ_B1),
    .REQ_F70(REQ_F70), .REQ_F71(REQ_F71), .REQ_F30(REQ_F30), .REQ_F31(REQ_F31),
    .REQ_OP0(REQ_OP0), .REQ_OP1(REQ_OP1),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_F7(ALU_F7), .ALU_F3(ALU_F3), .ALU_OP(ALU_OP),
    .ALU_Y(ALU_Y), .ALU_C(ALU_C), .ALU_V(ALU_V), .ALU_N(ALU_N), .ALU_ZERO(ALU_ZERO),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_Y(RSP_Y), .RSP_FLAGS(RSP_FLAGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_add(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    fa[p] = a; fb[p] = b; f7[p] = sub ? 7'h20 : 7'h00; f3[p] = 3'd0; fop[p] = 8'h33;
  endtask

  task automatic rand_port(input int p);
    fa[p] = $urandom;
    fb[p] = ($urandom_range(0, 3) == 0) ? fa[p] : $urandom;
    fop[p] = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 4))
      0: begin f7[p] = 7'h00; f3[p] = 3'd0; end
      1: begin f7[p] = 7'h20; f3[p] = 3'd0; end
      2: begin f7[p] = 7'h00; f3[p] = 3'd4; end
      3: begin f7[p] = 7'h00; f3[p] = 3'd6; end
      default: begin f7[p] = 7'h00; f3[p] = 3'd7; end
    endcase
  endtask

  task automatic reset_dut();
    RST = 1'b1; REQ_VALID = 2'b11; RSP_READY = 1'b0;
    @(posedge CLK); #1;
    chk("req_ready_in_reset", REQ_READY, 2'b00);
    @(posedge CLK); #1;
    chk("rst_alu_a", ALU_A, 0);
    chk("rst_alu_b", ALU_B, 0);
    chk("rst_alu_ctl", {ALU_F7, ALU_F3, ALU_OP}, 0);
    chk("rst_rsp_valid", RSP_VALID, 0);
    chk("rst_rsp_id", RSP_ID, 0);
    chk("rst_rsp_y", RSP_Y, 0);
    chk("rst_rsp_flags", RSP_FLAGS, 0);
    REQ_VALID = 2'b00; RST = 1'b0; m_last = 1'b1;
  endtask

  // One complete transaction from the idle cycle through the handshake.
  task automatic run_op(input logic [1:0] v, input int hold, input logic [1:0] blip);
    int g;
    logic [1:0]   eg;
    logic [W+3:0] r;
    logic [W-1:0] ea, eb;
    logic [6:0]   e7;
    logic [2:0]   e3;
    logic [OW-1:0] eop;
    REQ_VALID = REQ_VALID | v;
    RSP_READY = (hold == 0);
    #1;
    if (REQ_VALID == 2'b11) g = m_last ? 0 : 1;
    else g = REQ_VALID[1] ? 1 : 0;
    eg = (g == 1) ? 2'b10 : 2'b01;
    chk("req_ready_idle", REQ_READY, eg);
    ea = fa[g]; eb = fb[g]; e7 = f7[g]; e3 = f3[g]; eop = fop[g];
    r = ref_alu(ea, eb, e7, e3);
    @(posedge CLK); #1;
    REQ_VALID[g] = 1'b0;
    chk("req_ready_exec", REQ_READY, 2'b00);
    chk("rsp_valid_exec", RSP_VALID, 0);
    chk("alu_a", ALU_A, ea);
    chk("alu_b", ALU_B, eb);
    chk("alu_ctl", {ALU_F7, ALU_F3, ALU_OP}, {e7, e3, eop});
    @(posedge CLK); #1;
    chk("rsp_valid", RSP_VALID, 1);
    chk("rsp_id", RSP_ID, g);
    chk("rsp_y", RSP_Y, r[W-1:0]);
    chk("rsp_flags", RSP_FLAGS, r[W+3:W]);
    last_id = RSP_ID; last_y = RSP_Y; last_flags = RSP_FLAGS;
    REQ_VALID = REQ_VALID | blip;
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK); #1;
      chk("hold_valid", RSP_VALID, 1);
      chk("hold_id", RSP_ID, g);
      chk("hold_y", RSP_Y, r[W-1:0]);
      chk("hold_flags", RSP_FLAGS, r[W+3:W]);
      chk("hold_req_ready", REQ_READY, 2'b00);
      chk("hold_alu_a", ALU_A, ea);
    end
    REQ_VALID = REQ_VALID & ~blip;
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    chk("rsp_valid_after_hs", RSP_VALID, 0);
    chk("alu_a_held_idle", ALU_A, ea);
    m_last = g[0];
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      fa[p] = '0; fb[p] = '0; f7[p] = '0; f3[p] = '0; fop[p] = '0;
    end
    RST = 1'b1; REQ_VALID = 2'b00; RSP_READY = 1'b0;
    last_id = 1'b0; last_y = '0; last_flags = '0; m_last = 1'b1;

    // Single exec request: 5 + 3.
    reset_dut();
    set_add(0, 32'd5, 32'd3, 1'b0);
    run_op(2'b01, 0, 2'b00);
    chk("t1_id", last_id, 0);
    chk("t1_y", last_y, 32'd8);
    chk("t1_flags", last_flags, 4'b0000);

    // Both requesters continuously valid from reset alternate 0,1,0,1...
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < 2; p++) if (!REQ_VALID[p]) rand_port(p);
      run_op(2'b11, 0, 2'b00);
      chk("rr_order", last_id, k % 2);
    end
    REQ_VALID = 2'b00;

    // SUB 7-7 with a 5-cycle stall on the response.
    set_add(0, 32'd7, 32'd7, 1'b1);
    run_op(2'b01, 5, 2'b00);
    chk("t3_y", last_y, 0);
    chk("t3_zero", last_flags[0], 1);

    // Signed overflow from port 1, then a tie must go to port 0.
    set_add(1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op(2'b10, 0, 2'b00);
    chk("t4_id", last_id, 1);
    chk("t4_y", last_y, 32'h8000_0000);
    chk("t4_flags", last_flags, 4'b0110);
    rand_port(0); rand_port(1);
    run_op(2'b11, 0, 2'b00);
    chk("t4_tie", last_id, 0);
    REQ_VALID = 2'b00;

    // Reset while in EXEC: request still pending is re-accepted.
    rand_port(0);
    REQ_VALID = 2'b01; RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("t5e_rsp_valid", RSP_VALID, 0);
    chk("t5e_alu_a", ALU_A, 0);
    chk("t5e_alu_b", ALU_B, 0);
    chk("t5e_alu_ctl", {ALU_F7, ALU_F3, ALU_OP}, 0);
    chk("t5e_req_ready", REQ_READY, 2'b00);
    RST = 1'b0; m_last = 1'b1;
    #1;
    chk("t5e_reaccept", REQ_READY, 2'b01);
    run_op(2'b01, 0, 2'b00);
    chk("t5e_id", last_id, 0);

    // Reset while in RESP: the pending response is discarded.
    rand_port(1);
    REQ_VALID = 2'b10; RSP_READY = 1'b0;
    @(posedge CLK); #1;
    REQ_VALID = 2'b00;
    @(posedge CLK); #1;
    chk("t5r_in_resp", RSP_VALID, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("t5r_rsp_valid", RSP_VALID, 0);
    chk("t5r_rsp_y", RSP_Y, 0);
    chk("t5r_rsp_flags", RSP_FLAGS, 0);
    chk("t5r_rsp_id", RSP_ID, 0);
    RST = 1'b0; m_last = 1'b1; RSP_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("t5r_no_stale", RSP_VALID, 0);
    end

    // Port 1 valid only during RESP, dropped before idle: never served.
    rand_port(0); rand_port(1);
    run_op(2'b01, 3, 2'b10);
    chk("t6_req_ready", REQ_READY, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("t6_no_rsp", RSP_VALID, 0);
      chk("t6_no_accept", ALU_A, fa[0]);
    end

    // Randomized traffic: random masks, stalls and short-lived requests.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] v, bl;
      v = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) if (v[p] && !REQ_VALID[p]) rand_port(p);
      bl = ~(REQ_VALID | v) & 2'($urandom_range(0, 3));
      run_op(v, $urandom_range(0, 3), bl);
    end
    REQ_VALID = 2'b00;
    @(posedge CLK); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
